// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader.
//   loader_state_e : loader FSM states
//   HDR_BYTES      : header length (word count, high byte first)
//   BYTES_PER_WORD : bytes per instruction word (MSB first on the wire)
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // States in which a load is in flight: byte input open, CPU held.
  function automatic logic is_loading(input loader_state_e s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA) || (s == CHK);
  endfunction

endpackage

// File: rtl/instr_mem_loader_packer.sv
// byte_to_word_packer: assembles MSB-first bytes into 32-bit words.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clr          restart assembly at byte 0 (new load)
//   i_vld, i_byte  byte accepted this cycle
//   o_last         combinational: the accepted byte completes a word
//   o_word         last completed word (held until the next one)
//   o_word_vld     one-cycle pulse, the cycle after the completing byte
module byte_to_word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_vld,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic [31:0] o_word,
  output logic        o_word_vld
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;
  logic [31:0] r_word;
  logic        r_word_vld;

  assign o_last     = i_vld && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word     = r_word;
  assign o_word_vld = r_word_vld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_word     <= '0;
      r_word_vld <= 1'b0;
    end else begin
      r_word_vld <= 1'b0;
      if (i_clr) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (i_vld) begin
        r_cnt   <= r_cnt + 2'd1;
        r_shift <= {r_shift[15:0], i_byte};
        if (o_last) begin
          r_word     <= {r_shift, i_byte};
          r_word_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: receives a byte-serial program image (2-byte word
// count N, then N words MSB first) and writes it into instruction memory,
// holding the CPU stalled (Busy) while loading.
// Ports:
//   Clk, Reset             clock, synchronous active-high reset
//   Start                  pulse: begin a load (ignored while Busy)
//   InValid, InData, InReady   byte stream, transfer on InValid && InReady
//   MemWrite, MemAddress, MemWriteData   instruction memory write port
//   Busy, Done, Error      status (Done/Error sticky until next Start)
//   WordsLoaded            words written in current/last load
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing
// checksum byte making the XOR of all image bytes 0x00.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int          DEPTH     = 128,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        InValid,
  input  logic [7:0]  InData,
  output logic        InReady,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  WordsLoaded
);

  localparam int NW = 8 * HDR_BYTES;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e BODY_END = CHK;
`else
  localparam loader_state_e BODY_END = DONE;
`endif

  loader_state_e r_state, w_state_nxt;
  logic [7:0]    r_hdr_hi;
  logic [NW-1:0] r_n;
  logic [NW+1:0] r_byte_cnt;
  logic [31:0]   r_addr;
  logic [7:0]    r_words;
  logic          r_done, r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    r_xsum;
`endif

  logic          w_accept, w_start, w_data_last, w_word_last, w_wr;
  logic [NW-1:0] w_hdr_n;
  logic [NW+1:0] w_last_idx;
  logic [31:0]   w_word;

  assign w_accept   = InValid && InReady;
  assign w_start    = Start && !is_loading(r_state);
  assign w_hdr_n    = {r_hdr_hi, InData};
  // Index of the final data byte: 4N-1 (N >= 1 whenever we are in DATA).
  assign w_last_idx = {r_n - NW'(1), 2'b11};
  assign w_data_last = (r_byte_cnt == w_last_idx);

  byte_to_word_packer u_packer (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_clr      (w_start),
    .i_vld      (w_accept && (r_state == DATA)),
    .i_byte     (InData),
    .o_last     (w_word_last),
    .o_word     (w_word),
    .o_word_vld (w_wr)
  );

  always_comb begin
    w_state_nxt = r_state;
    InReady     = 1'b0;
    Busy        = 1'b0;
    if (is_loading(r_state)) begin
      InReady = 1'b1;
      Busy    = 1'b1;
    end
    case (r_state)
      IDLE, DONE, ERR: if (Start) w_state_nxt = HDR_HI;
      HDR_HI:          if (w_accept) w_state_nxt = HDR_LO;
      HDR_LO: begin
        if (w_accept) begin
          if (w_hdr_n > NW'(DEPTH))  w_state_nxt = ERR;
          else if (w_hdr_n == '0)    w_state_nxt = BODY_END;
          else                       w_state_nxt = DATA;
        end
      end
      DATA:            if (w_accept && w_data_last) w_state_nxt = BODY_END;
`ifdef LOADER_CHECKSUM_EN
      CHK:             if (w_accept) w_state_nxt = ((r_xsum ^ InData) == 8'h00) ? DONE : ERR;
`else
      CHK:             w_state_nxt = ERR;
`endif
      default:         w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_hdr_hi   <= '0;
      r_n        <= '0;
      r_byte_cnt <= '0;
      r_addr     <= BASE_ADDR;
      r_words    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xsum     <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        // A write still in flight from the previous image completes with
        // its own address this cycle; the new load restarts at BASE_ADDR.
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_words    <= '0;
        r_byte_cnt <= '0;
        r_addr     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
        r_xsum     <= '0;
`endif
      end else begin
        if (w_wr)        r_addr  <= r_addr + 32'(BYTES_PER_WORD);
        // Counted on the edge that raises MemWrite for this word.
        if (w_word_last) r_words <= r_words + 8'd1;
        if (w_accept && (r_state == HDR_HI)) r_hdr_hi   <= InData;
        if (w_accept && (r_state == HDR_LO)) r_n        <= w_hdr_n;
        if (w_accept && (r_state == DATA))   r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (w_accept) r_xsum <= r_xsum ^ InData;
`endif
        if ((w_state_nxt == DONE) && (r_state != DONE)) r_done <= 1'b1;
        if ((w_state_nxt == ERR)  && (r_state != ERR))  r_err  <= 1'b1;
      end
    end
  end

  assign MemWrite     = w_wr;
  assign MemAddress   = r_addr;
  assign MemWriteData = w_word;
  assign Done         = r_done;
  assign Error        = r_err;
  assign WordsLoaded  = r_words;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  logic        Clk = 1'b0;
  logic        Reset, Start, InValid;
  logic [7:0]  InData;
  logic        InReady, MemWrite, Busy, Done, Error;
  logic [31:0] MemAddress, MemWriteData;
  logic [7:0]  WordsLoaded;

  instr_mem_loader #(.DEPTH(128), .BASE_ADDR(32'h0)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InData(InData),
    .InReady(InReady), .MemWrite(MemWrite), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .Busy(Busy), .Done(Done), .Error(Error),
    .WordsLoaded(WordsLoaded)
  );

  always #5 Clk = ~Clk;

  int          n_asrt = 0;
  int          n_fail = 0;
  int          wr_cnt = 0;
  logic [31:0] cap_addr [0:1023];
  logic [31:0] cap_data [0:1023];
  logic [31:0] tb_mem   [0:127];
  logic [7:0]  tb_x;

  // Write-port capture on the falling edge (memory image + write log).
  always @(negedge Clk) begin
    if (MemWrite === 1'b1) begin
      cap_addr[wr_cnt % 1024] = MemAddress;
      cap_data[wr_cnt % 1024] = MemWriteData;
      tb_mem[MemAddress[8:2]] = MemWriteData;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    InValid = 1'b1; InData = b; tb_x = tb_x ^ b;
    tick();
    InValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8]);
  endtask

  task automatic start_load();
    Start = 1'b1; tb_x = 8'h00;
    tick();
    Start = 1'b0;
  endtask

  // Closes an image: checksum byte when enabled, then one settling cycle.
  task automatic finish_img();
`ifdef LOADER_CHECKSUM_EN
    send(tb_x);
`endif
    tick();
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_inready"}, 32'(InReady), 32'd0);
    chk({p, "_memwrite"}, 32'(MemWrite), 32'd0);
    chk({p, "_busy"}, 32'(Busy), 32'd0);
    chk({p, "_done"}, 32'(Done), 32'd0);
    chk({p, "_error"}, 32'(Error), 32'd0);
    chk({p, "_addr"}, MemAddress, 32'h0);
    chk({p, "_wdata"}, MemWriteData, 32'h0);
    chk({p, "_words"}, 32'(WordsLoaded), 32'd0);
  endtask

  initial begin
    int base, bad;
    logic [31:0] exp_w;
    Reset = 1'b1; Start = 1'b0; InValid = 1'b0; InData = 8'h00; tb_x = 8'h00;
    tick(); tick();
    chk_reset_vals("rst");
    Reset = 1'b0;
    tick();
    chk("idle_inready", 32'(InReady), 32'd0);

    // Two-word image with a stall cycle inside the first word.
    base = wr_cnt;
    start_load();
    chk("a_busy", 32'(Busy), 32'd1);
    chk("a_inready", 32'(InReady), 32'd1);
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h02); tick(); send(8'h00); send(8'h0E);
    chk("a_w0_strobe", 32'(MemWrite), 32'd1);
    chk("a_w0_addr", MemAddress, 32'h0);
    chk("a_w0_data", MemWriteData, 32'h2002000E);
    chk("a_w0_words", 32'(WordsLoaded), 32'd1);
    send_word(32'h00430827);
    finish_img();
    chk("a_nwr", 32'(wr_cnt - base), 32'd2);
    chk("a_w1_addr", cap_addr[(base + 1) % 1024], 32'h4);
    chk("a_w1_data", cap_data[(base + 1) % 1024], 32'h00430827);
    chk("a_done", 32'(Done), 32'd1);
    chk("a_error", 32'(Error), 32'd0);
    chk("a_busy_end", 32'(Busy), 32'd0);
    chk("a_inready_end", 32'(InReady), 32'd0);
    chk("a_words", 32'(WordsLoaded), 32'd2);

    // Bytes offered while not ready are ignored.
    InValid = 1'b1; InData = 8'hFF;
    repeat (3) tick();
    InValid = 1'b0;
    chk("b_nwr", 32'(wr_cnt - base), 32'd2);
    chk("b_done", 32'(Done), 32'd1);
    chk("b_state_idle", 32'(InReady), 32'd0);

    // Oversized header: N = 129.
    base = wr_cnt;
    start_load();
    chk("c_done_clr", 32'(Done), 32'd0);
    chk("c_words_clr", 32'(WordsLoaded), 32'd0);
    send(8'h00); send(8'h81);
    chk("c_error", 32'(Error), 32'd1);
    chk("c_busy", 32'(Busy), 32'd0);
    chk("c_inready", 32'(InReady), 32'd0);
    tick();
    chk("c_nwr", 32'(wr_cnt - base), 32'd0);
    chk("c_done", 32'(Done), 32'd0);

    // Full-depth image (N = 128), Start pulse mid-load must be ignored.
    base = wr_cnt;
    start_load();
    chk("d_error_clr", 32'(Error), 32'd0);
    send(8'h00); send(8'h80);
    for (int i = 0; i < 512; i++) begin
      if (i == 5) Start = 1'b1;
      send(8'(i));
      Start = 1'b0;
    end
    finish_img();
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      exp_w = {8'(4*k), 8'(4*k + 1), 8'(4*k + 2), 8'(4*k + 3)};
      if (cap_addr[(base + k) % 1024] !== 32'(4*k) || cap_data[(base + k) % 1024] !== exp_w) bad++;
    end
    chk("d_nwr", 32'(wr_cnt - base), 32'd128);
    chk("d_bad_words", 32'(bad), 32'd0);
    chk("d_last_addr", cap_addr[(base + 127) % 1024], 32'h1FC);
    chk("d_last_data", cap_data[(base + 127) % 1024], 32'hFCFDFEFF);
    chk("d_done", 32'(Done), 32'd1);
    chk("d_error", 32'(Error), 32'd0);
    chk("d_words", 32'(WordsLoaded), 32'd128);

    // Empty image.
    base = wr_cnt;
    start_load();
    send(8'h00); send(8'h00);
    finish_img();
    chk("e_done", 32'(Done), 32'd1);
    chk("e_error", 32'(Error), 32'd0);
    chk("e_busy", 32'(Busy), 32'd0);
    chk("e_nwr", 32'(wr_cnt - base), 32'd0);
    chk("e_words", 32'(WordsLoaded), 32'd0);

    // Reset after two of three words, then reload.
    base = wr_cnt;
    start_load();
    send(8'h00); send(8'h03);
    send_word(32'hAABBCCDD);
    send_word(32'h11223344);
    send(8'h55); send(8'h66);
    Reset = 1'b1;
    tick();
    chk_reset_vals("f_rst");
    Reset = 1'b0;
    chk("f_nwr", 32'(wr_cnt - base), 32'd2);
    chk("f_mem0", tb_mem[0], 32'hAABBCCDD);
    chk("f_mem1", tb_mem[1], 32'h11223344);
    tick();
    start_load();
    send(8'h00); send(8'h01);
    send_word(32'hDEADBEEF);
    chk("f_reload_addr", MemAddress, 32'h0);
    chk("f_reload_strobe", 32'(MemWrite), 32'd1);
    finish_img();
    chk("f_reload_mem0", tb_mem[0], 32'hDEADBEEF);
    chk("f_reload_mem1", tb_mem[1], 32'h11223344);
    chk("f_reload_done", 32'(Done), 32'd1);
    chk("f_reload_words", 32'(WordsLoaded), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // 00^01^12^34^56^78 = 0x09: checksum 0x09 passes, 0x08 fails.
    start_load();
    send(8'h00); send(8'h01); send_word(32'h12345678);
    send(8'h09); tick();
    chk("g_done", 32'(Done), 32'd1);
    chk("g_error", 32'(Error), 32'd0);
    base = wr_cnt;
    start_load();
    send(8'h00); send(8'h01); send_word(32'h12345678);
    send(8'h08); tick();
    chk("g_bad_error", 32'(Error), 32'd1);
    chk("g_bad_done", 32'(Done), 32'd0);
    chk("g_bad_nwr", 32'(wr_cnt - base), 32'd1);
    chk("g_bad_addr", cap_addr[base % 1024], 32'h0);
    chk("g_bad_data", cap_data[base % 1024], 32'h12345678);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
